// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants and helpers for the parametrised serial pattern detector
package seq_detect_pkg;
   localparam int SEQ_PLEN_MAX = 32;
   localparam logic OVL_ON  = 1'b1;
   localparam logic OVL_OFF = 1'b0;
   function automatic int fill_width(input int plen);
      return $clog2(plen);
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that saturates at all-ones; clear takes priority but still counts a same-cycle increment
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;
   always_comb w_next = i_clr ? WIDTH'(i_inc) : (i_inc && !(&r_q)) ? r_q + 1'b1 : r_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_q <= '0;
      else          r_q <= w_next;
   assign o_q = r_q;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: Mealy serial-pattern detector with runtime pattern/overlap reload and match counter
// The fill count doubles as the FSM state: a match is only possible once PLEN-1 bits are held.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int              PLEN        = 4,
   parameter logic [PLEN-1:0] DEF_PATTERN = 4'b1001,
   parameter logic            DEF_OVERLAP = OVL_ON,
   parameter int              CNT_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in,
   input  logic             i_in_valid,
   input  logic             i_cfg_load,
   input  logic [PLEN-1:0]  i_cfg_pattern,
   input  logic             i_cfg_overlap,
   input  logic             i_count_clr,
   output logic             o_out,
   output logic [CNT_W-1:0] o_match_count
);
   localparam int FILL_W = fill_width(PLEN);
   logic [PLEN-2:0]   r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PLEN-1:0]   r_pat;
   logic              r_ovl;
   logic [PLEN-1:0]   w_window;
   logic              w_full;
   logic              w_accept;
   logic              w_match;
   logic              w_restart;
   always_comb begin
      w_window  = {r_hist, i_in};
      w_full    = r_fill == FILL_W'(PLEN - 1);
      w_accept  = i_in_valid & ~i_cfg_load;
      w_match   = w_accept & w_full & (w_window == r_pat);
      w_restart = w_match & (r_ovl == OVL_OFF);
   end
   // Shifting through the full window keeps PLEN=2 legal, where hist is a single bit.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= DEF_PATTERN;
         r_ovl  <= DEF_OVERLAP;
      end else if (i_cfg_load) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= i_cfg_pattern;
         r_ovl  <= i_cfg_overlap;
      end else if (w_accept) begin
         r_hist <= w_restart ? '0 : w_window[PLEN-2:0];
         r_fill <= w_restart ? '0 : w_full ? r_fill : r_fill + 1'b1;
      end
   assign o_out = w_match;
   sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_match),
      .i_clr   (i_count_clr),
      .o_q     (o_match_count)
   );
endmodule
